// File: rtl/sme_pkg.sv
// Shared types and defaults for the string-match engine.
// Holds the FSM state encoding, default sizes and address-width helpers.
package sme_pkg;

   localparam int unsigned BYTE_DEF        = 8;
   localparam int unsigned MAX_STRING_DEF  = 32;
   localparam int unsigned MAX_PATTERN_DEF = 8;
   localparam logic [7:0]  WILDCARD_DEF    = 8'h2E;

   localparam int unsigned STR_IDX_W_DEF = $clog2(MAX_STRING_DEF);
   localparam int unsigned STR_LEN_W_DEF = $clog2(MAX_STRING_DEF + 1);
   localparam int unsigned PAT_IDX_W_DEF = $clog2(MAX_PATTERN_DEF);
   localparam int unsigned PAT_LEN_W_DEF = $clog2(MAX_PATTERN_DEF + 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_STR = 3'd1,
      ST_LOAD_PAT = 3'd2,
      ST_SCAN     = 3'd3,
      ST_DONE     = 3'd4
   } sme_state_e;

   // Bits needed to address a buffer of the given depth.
   function automatic int unsigned idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Bits needed to hold a length of 0..depth.
   function automatic int unsigned len_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sme_window_cmp.sv
// Combinational compare of one string window against the stored pattern.
// Positions at or beyond pat_len are ignored; the wildcard matches anything when enabled.
module sme_window_cmp
   import sme_pkg::*;
#(
   parameter int unsigned     BYTE        = BYTE_DEF,
   parameter int unsigned     MAX_PATTERN = MAX_PATTERN_DEF,
   parameter int unsigned     PAT_LEN_W   = PAT_LEN_W_DEF,
   parameter logic [BYTE-1:0] WILDCARD    = BYTE'(WILDCARD_DEF),
   parameter bit              WILD_EN     = 1'b1
) (
   input  logic [MAX_PATTERN-1:0][BYTE-1:0] window,
   input  logic [MAX_PATTERN-1:0][BYTE-1:0] pattern,
   input  logic [PAT_LEN_W-1:0]             pat_len,
   output logic                             hit
);

   always_comb begin
      hit = 1'b1;
      for (int unsigned i = 0; i < MAX_PATTERN; i++) begin
         if ((PAT_LEN_W'(i) < pat_len) && (window[i] != pattern[i]) &&
             !(WILD_EN && (pattern[i] == WILDCARD))) begin
            hit = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sme_multi.sv
// Multi-match string search: loads a string and a pattern, then reports every
// start position where the pattern occurs, one candidate per cycle, followed by a last beat.
module sme_multi
   import sme_pkg::*;
#(
   parameter int unsigned     BYTE        = BYTE_DEF,
   parameter int unsigned     MAX_STRING  = MAX_STRING_DEF,
   parameter int unsigned     MAX_PATTERN = MAX_PATTERN_DEF,
   parameter logic [BYTE-1:0] WILDCARD    = BYTE'(WILDCARD_DEF),
   parameter bit              WILD_EN     = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [BYTE-1:0]               chardata,
   input  logic                          isstring,
   input  logic                          ispattern,
   output logic                          valid,
   output logic                          match,
   output logic                          last,
   output logic [idx_w(MAX_STRING)-1:0]  match_index
);

   localparam int unsigned STR_IDX_W = idx_w(MAX_STRING);
   localparam int unsigned STR_LEN_W = len_w(MAX_STRING);
   localparam int unsigned PAT_IDX_W = idx_w(MAX_PATTERN);
   localparam int unsigned PAT_LEN_W = len_w(MAX_PATTERN);
   localparam int unsigned LEN_W     = (STR_LEN_W > PAT_LEN_W) ? STR_LEN_W : PAT_LEN_W;
   localparam int unsigned WIN_W     = STR_IDX_W + PAT_IDX_W + 1;

   sme_state_e                        state_q, state_d;
   logic [MAX_STRING-1:0][BYTE-1:0]   str_q, str_d;
   logic [MAX_PATTERN-1:0][BYTE-1:0]  pat_q, pat_d;
   logic [STR_LEN_W-1:0]              str_len_q, str_len_d;
   logic [PAT_LEN_W-1:0]              pat_len_q, pat_len_d;
   logic [STR_IDX_W-1:0]              p_q, p_d;
   logic                              valid_q, valid_d;
   logic                              match_q, match_d;
   logic                              last_q, last_d;
   logic [STR_IDX_W-1:0]              idx_q, idx_d;

   logic [MAX_PATTERN-1:0][BYTE-1:0]  window_c;
   logic [WIN_W-1:0]                  pos_c;
   logic [LEN_W-1:0]                  last_p_c;
   logic                              has_cand_c;
   logic                              hit_c;

   // Slice the window starting at candidate p; positions past the buffer read as zero.
   always_comb begin
      window_c = '0;
      pos_c    = '0;
      for (int unsigned i = 0; i < MAX_PATTERN; i++) begin
         pos_c = WIN_W'(p_q) + WIN_W'(i);
         if (pos_c < WIN_W'(MAX_STRING)) begin
            window_c[i] = str_q[STR_IDX_W'(pos_c)];
         end
      end
   end

   assign has_cand_c = (pat_len_q != '0) && (LEN_W'(pat_len_q) <= LEN_W'(str_len_q));
   assign last_p_c   = LEN_W'(str_len_q) - LEN_W'(pat_len_q);

   sme_window_cmp #(
      .BYTE        (BYTE),
      .MAX_PATTERN (MAX_PATTERN),
      .PAT_LEN_W   (PAT_LEN_W),
      .WILDCARD    (WILDCARD),
      .WILD_EN     (WILD_EN)
   ) u_cmp (
      .window  (window_c),
      .pattern (pat_q),
      .pat_len (pat_len_q),
      .hit     (hit_c)
   );

   // Load sequencing, candidate stepping and result-beat generation.
   always_comb begin
      state_d   = state_q;
      str_d     = str_q;
      pat_d     = pat_q;
      str_len_d = str_len_q;
      pat_len_d = pat_len_q;
      p_d       = p_q;
      valid_d   = 1'b0;
      match_d   = 1'b0;
      last_d    = 1'b0;
      idx_d     = '0;

      case (state_q)
         ST_IDLE, ST_LOAD_STR, ST_LOAD_PAT: begin
            if (ispattern) begin
               if (state_q == ST_LOAD_PAT) begin
                  if (pat_len_q < PAT_LEN_W'(MAX_PATTERN)) begin
                     pat_d[PAT_IDX_W'(pat_len_q)] = chardata;
                     pat_len_d                    = pat_len_q + PAT_LEN_W'(1);
                  end
               end else begin
                  pat_d[0]  = chardata;
                  pat_len_d = PAT_LEN_W'(1);
                  state_d   = ST_LOAD_PAT;
               end
            end else if (isstring) begin
               if (state_q == ST_LOAD_STR) begin
                  if (str_len_q < STR_LEN_W'(MAX_STRING)) begin
                     str_d[STR_IDX_W'(str_len_q)] = chardata;
                     str_len_d                    = str_len_q + STR_LEN_W'(1);
                  end
               end else begin
                  str_d[0]  = chardata;
                  str_len_d = STR_LEN_W'(1);
                  state_d   = ST_LOAD_STR;
               end
            end else if (state_q == ST_LOAD_STR) begin
               state_d = ST_IDLE;
            end else if (state_q == ST_LOAD_PAT) begin
               // With no candidates SCAN has nothing to do, so step straight to DONE.
               p_d     = '0;
               state_d = has_cand_c ? ST_SCAN : ST_DONE;
            end
         end

         ST_SCAN: begin
            valid_d = hit_c;
            match_d = hit_c;
            idx_d   = hit_c ? p_q : '0;
            if (LEN_W'(p_q) >= last_p_c) begin
               state_d = ST_DONE;
            end else begin
               p_d = p_q + STR_IDX_W'(1);
            end
         end

         ST_DONE: begin
            valid_d = 1'b1;
            last_d  = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         str_len_q <= '0;
         pat_len_q <= '0;
         p_q       <= '0;
         valid_q   <= 1'b0;
         match_q   <= 1'b0;
         last_q    <= 1'b0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         str_len_q <= str_len_d;
         pat_len_q <= pat_len_d;
         p_q       <= p_d;
         valid_q   <= valid_d;
         match_q   <= match_d;
         last_q    <= last_d;
         idx_q     <= idx_d;
      end
   end

   // Character buffers carry no reset; the length counters qualify their contents.
   always_ff @(posedge clk) begin
      str_q <= str_d;
      pat_q <= pat_d;
   end

   assign valid       = valid_q;
   assign match       = match_q;
   assign last        = last_q;
   assign match_index = idx_q;

endmodule

// File: tb/tb_sme_multi.sv
// Self-checking bench for sme_multi: two instances (wildcard on/off) share stimulus,
// expected beats are queued with their cycle numbers and popped as the DUTs emit them.
module tb_sme_multi;
   import sme_pkg::*;

   localparam int unsigned IW = STR_IDX_W_DEF;

   typedef struct {
      int             cyc;
      logic           m;
      logic           l;
      logic [IW-1:0]  ix;
   } beat_t;

   typedef struct {
      logic [255:0] s;
      int           slen;
      logic [127:0] pt;
      int           plen;
      logic [31:0]  mw;
      logic [31:0]  mnw;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    chardata;
   logic          isstring;
   logic          ispattern;
   logic          v0, m0, l0, v1, m1, l1;
   logic [IW-1:0] ix0, ix1;

   int    cyc    = 0;
   int    checks = 0;
   int    errors = 0;
   beat_t sbq [2][$];
   vec_t  vecs [12];

   sme_multi dut (
      .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
      .valid(v0), .match(m0), .last(l0), .match_index(ix0)
   );

   sme_multi #(.WILD_EN(1'b0)) dut_nw (
      .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
      .valid(v1), .match(m1), .last(l1), .match_index(ix1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_port(input int d, input logic v, input logic m, input logic l,
                             input logic [IW-1:0] ix);
      beat_t e;
      while (sbq[d].size() > 0) begin
         e = sbq[d][0];
         if (e.cyc >= cyc) break;
         void'(sbq[d].pop_front());
         checks++; errors++;
         $display("FAIL missing_beat dut%0d: absent by cyc %0d, required m=%b l=%b idx=%0d at cyc %0d",
                  d, cyc, e.m, e.l, e.ix, e.cyc);
      end
      if (v !== 1'b1) begin
         checks++;
         if (v !== 1'b0 || m !== 1'b0 || l !== 1'b0 || ix !== '0) begin
            errors++;
            $display("FAIL idle_outputs dut%0d cyc %0d: got v=%b m=%b l=%b idx=%0d, required all 0",
                     d, cyc, v, m, l, ix);
         end
      end else if (sbq[d].size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_beat dut%0d cyc %0d: got m=%b l=%b idx=%0d, required no beat",
                  d, cyc, m, l, ix);
      end else begin
         e = sbq[d].pop_front();
         checks++;
         if (m !== e.m || l !== e.l || ix !== e.ix || cyc != e.cyc) begin
            errors++;
            $display("FAIL beat dut%0d: got m=%b l=%b idx=%0d cyc %0d, required m=%b l=%b idx=%0d cyc %0d",
                     d, m, l, ix, cyc, e.m, e.l, e.ix, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      check_port(0, v0, m0, l0, ix0);
      check_port(1, v1, m1, l1, ix1);
   end

   task automatic check_zero(input string name);
      checks++;
      if ({v0, m0, l0, ix0, v1, m1, l1, ix1} !== '0) begin
         errors++;
         $display("FAIL %s: got v=%b/%b m=%b/%b l=%b/%b idx=%0d/%0d, required all 0",
                  name, v0, v1, m0, m1, l0, l1, ix0, ix1);
      end
   endtask

   task automatic tick(input logic [7:0] c, input logic s, input logic p);
      chardata  = c;
      isstring  = s;
      ispattern = p;
      @(posedge clk);
      #1;
      chardata  = 8'h00;
      isstring  = 1'b0;
      ispattern = 1'b0;
   endtask

   task automatic load_str(input logic [255:0] s, input int len);
      for (int i = 0; i < len; i++) tick(s[(len-1-i)*8 +: 8], 1'b1, 1'b0);
   endtask

   task automatic load_pat(input logic [127:0] s, input int len);
      for (int i = 0; i < len; i++) tick(s[(len-1-i)*8 +: 8], 1'b0, 1'b1);
   endtask

   // Called right after the final pattern edge: candidate k lands 2+k edges later, last after all.
   task automatic push_exp(input logic [31:0] mw, input logic [31:0] mnw, input int n);
      beat_t b;
      int    e0 = cyc;
      for (int p = 0; p < n; p++) begin
         b.cyc = e0 + 2 + p; b.m = 1'b1; b.l = 1'b0; b.ix = IW'(p);
         if (mw[p])  sbq[0].push_back(b);
         if (mnw[p]) sbq[1].push_back(b);
      end
      b.cyc = e0 + 2 + n; b.m = 1'b0; b.l = 1'b1; b.ix = '0;
      sbq[0].push_back(b);
      sbq[1].push_back(b);
   endtask

   function automatic int n_cand(input int slen, input int plen);
      int s = (slen > 32) ? 32 : slen;
      int p = (plen > 8) ? 8 : plen;
      return (p == 0 || p > s) ? 0 : s - p + 1;
   endfunction

   task automatic wait_drain(input int maxc);
      int n = 0;
      while ((sbq[0].size() > 0 || sbq[1].size() > 0) && n < maxc) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (sbq[0].size() > 0 || sbq[1].size() > 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d/%0d beats still pending after %0d cycles, required 0",
                  sbq[0].size(), sbq[1].size(), maxc);
         sbq[0].delete();
         sbq[1].delete();
      end
   endtask

   task automatic pattern_only(input logic [127:0] pt, input int plen, input int slen,
                               input logic [31:0] mw, input logic [31:0] mnw);
      load_pat(pt, plen);
      push_exp(mw, mnw, n_cand(slen, plen));
      tick(8'h00, 1'b0, 1'b0);
      wait_drain(80);
      tick(8'h00, 1'b0, 1'b0);
   endtask

   task automatic run_vec(input vec_t v);
      load_str(v.s, v.slen);
      pattern_only(v.pt, v.plen, v.slen, v.mw, v.mnw);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{256'("abcabc"),     6,  128'("abc"),        3,  32'h9,  32'h9};
      vecs[1]  = '{256'("aaaa"),       4,  128'("aa"),         2,  32'h7,  32'h7};
      vecs[2]  = '{256'("abcd"),       4,  128'("a.c"),        3,  32'h1,  32'h0};
      vecs[3]  = '{256'("ab"),         2,  128'("abc"),        3,  32'h0,  32'h0};
      vecs[4]  = '{256'("xyzxyz"),     6,  128'("yz"),         2,  32'h12, 32'h12};
      vecs[5]  = '{256'("hello"),      5,  128'("l"),          1,  32'hC,  32'hC};
      vecs[6]  = '{256'("a.c."),       4,  128'(".."),         2,  32'h7,  32'h0};
      vecs[7]  = '{256'("abc"),        3,  128'("abc"),        3,  32'h1,  32'h1};
      vecs[8]  = '{256'("abcdefghij"), 10, 128'("cdefghij"),   8,  32'h4,  32'h4};
      vecs[9]  = '{256'("abcdefghij"), 10, 128'("cdefghijXY"), 10, 32'h4,  32'h4};
      vecs[10] = '{256'("a.c"),        3,  128'("."),          1,  32'h7,  32'h2};
      vecs[11] = '{256'("abcd"),       4,  128'("d"),          1,  32'h8,  32'h8};

      reset     = 1'b1;
      chardata  = 8'h00;
      isstring  = 1'b0;
      ispattern = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_state");
      reset = 1'b0;
      tick(8'h00, 1'b0, 1'b0);

      for (int k = 0; k < 12; k++) run_vec(vecs[k]);

      // String retained across back-to-back patterns.
      load_str(256'("xyzxyz"), 6);
      pattern_only(128'("yz"), 2, 6, 32'h12, 32'h12);
      pattern_only(128'("zx"), 2, 6, 32'h4, 32'h4);

      // Both strobes high: the pattern strobe wins, so the string stays "abab".
      load_str(256'("abab"), 4);
      tick(8'h62, 1'b1, 1'b1);
      tick(8'h61, 1'b0, 1'b1);
      push_exp(32'h2, 32'h2, 3);
      tick(8'h00, 1'b0, 1'b0);
      wait_drain(80);
      tick(8'h00, 1'b0, 1'b0);

      // Strobes during SCAN/DONE are ignored and the string is kept.
      load_str(256'("xyzxyz"), 6);
      load_pat(128'("z"), 1);
      push_exp(32'h24, 32'h24, 6);
      tick(8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) tick(8'h71, 1'b1, (i % 2) == 1);
      wait_drain(80);
      tick(8'h00, 1'b0, 1'b0);
      pattern_only(128'("z"), 1, 6, 32'h24, 32'h24);

      // Overflow characters are dropped: only the 32nd position holds 'a'.
      for (int i = 0; i < 31; i++) tick(8'h62, 1'b1, 1'b0);
      tick(8'h61, 1'b1, 1'b0);
      tick(8'h63, 1'b1, 1'b0);
      tick(8'h63, 1'b1, 1'b0);
      pattern_only(128'("a"), 1, 32, 32'h8000_0000, 32'h8000_0000);

      // Reset in the middle of a 32-candidate scan.
      for (int i = 0; i < 32; i++) tick(8'h61, 1'b1, 1'b0);
      load_pat(128'("a"), 1);
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
      repeat (8) tick(8'h00, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check_zero("async_reset_outputs");
      sbq[0].delete();
      sbq[1].delete();
      repeat (3) tick(8'h00, 1'b0, 1'b0);
      check_zero("reset_held_outputs");
      reset = 1'b0;
      repeat (40) tick(8'h00, 1'b0, 1'b0);
      run_vec(vecs[0]);

      wait_drain(80);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
